// File: rtl/count_wrap_monitor_if.sv
// Bundles the monitored count and the monitor's status outputs.
// master = the side that drives count_in/clr; slave = the monitor itself.
interface count_wrap_monitor_if #(
  parameter int WIDTH  = 4,
  parameter int STAT_W = 8
) ();
  logic [WIDTH-1:0]  count_in;
  logic              clr;
  logic              dir;
  logic              step_up;
  logic              step_dn;
  logic              wrap_up;
  logic              wrap_dn;
  logic [STAT_W-1:0] up_wraps;
  logic [STAT_W-1:0] dn_wraps;
  logic              stalled;
  logic              jump_err;

  modport master (
    output count_in, clr,
    input  dir, step_up, step_dn, wrap_up, wrap_dn,
    input  up_wraps, dn_wraps, stalled, jump_err
  );

  modport slave (
    input  count_in, clr,
    output dir, step_up, step_dn, wrap_up, wrap_dn,
    output up_wraps, dn_wraps, stalled, jump_err
  );
endinterface

// File: rtl/count_wrap_monitor.sv
// Observer for an up/down counter: classifies each sample against the
// previous one (modulo 2^WIDTH), emits step/wrap pulses, keeps saturating
// wrap statistics, and flags stalls and illegal jumps. All outputs registered.
module count_wrap_monitor #(
  parameter int WIDTH     = 4,
  parameter int STALL_LIM = 8,
  parameter int STAT_W    = 8
) (
  input logic                 clk,
  input logic                 rst,
  count_wrap_monitor_if.slave mon
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  localparam logic [7:0]        LIM      = 8'(STALL_LIM);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  localparam logic [WIDTH-1:0]  ONE      = WIDTH'(1);

  logic [1:0]        state_reg,    state_next;
  logic [WIDTH-1:0]  prev_reg,     prev_next;
  logic [7:0]        stall_cnt_reg, stall_cnt_next;
  logic              dir_reg,      dir_next;
  logic              step_up_reg,  step_up_next;
  logic              step_dn_reg,  step_dn_next;
  logic              wrap_up_reg,  wrap_up_next;
  logic              wrap_dn_reg,  wrap_dn_next;
  logic [STAT_W-1:0] up_wraps_reg, up_wraps_next;
  logic [STAT_W-1:0] dn_wraps_reg, dn_wraps_next;
  logic              stalled_reg,  stalled_next;
  logic              jump_err_reg, jump_err_next;

  // Step classification. The +1 test comes first so that with WIDTH=1,
  // where +1 and -1 coincide, every change is treated as an up step.
  logic [WIDTH-1:0] delta;
  logic             is_eq, is_up, is_dn, is_jump;
  logic [7:0]       stall_cnt_inc;
  logic             jump_evt;

  assign delta         = mon.count_in - prev_reg;
  assign is_eq         = (delta == '0);
  assign is_up         = (delta == ONE);
  assign is_dn         = !is_up && (delta == '1);
  assign is_jump       = !is_eq && !is_up && !is_dn;
  assign stall_cnt_inc = (stall_cnt_reg == 8'hFF) ? stall_cnt_reg : stall_cnt_reg + 8'd1;

  // Next-state logic: FSM, classification, statistics and clr priority.
  always_comb begin
    state_next     = state_reg;
    prev_next      = prev_reg;
    stall_cnt_next = stall_cnt_reg;
    dir_next       = dir_reg;
    step_up_next   = 1'b0;
    step_dn_next   = 1'b0;
    wrap_up_next   = 1'b0;
    wrap_dn_next   = 1'b0;
    up_wraps_next  = up_wraps_reg;
    dn_wraps_next  = dn_wraps_reg;
    stalled_next   = stalled_reg;
    jump_err_next  = jump_err_reg;
    jump_evt       = 1'b0;

    case (state_reg)
      ST_INIT: begin
        // First sample after reset only seeds the history.
        prev_next  = mon.count_in;
        state_next = ST_TRACK;
      end
      ST_TRACK, ST_STALL: begin
        prev_next = mon.count_in;
        if (is_eq) begin
          // While already stalled the counter simply holds.
          if (state_reg == ST_TRACK) begin
            stall_cnt_next = stall_cnt_inc;
            if (stall_cnt_inc >= LIM) begin
              stalled_next = 1'b1;
              state_next   = ST_STALL;
            end
          end
        end else begin
          stall_cnt_next = 8'd0;
          stalled_next   = 1'b0;
          state_next     = ST_TRACK;
          if (is_up) begin
            step_up_next = 1'b1;
            dir_next     = 1'b1;
            if (prev_reg == '1) begin
              wrap_up_next = 1'b1;
              if (up_wraps_reg != STAT_MAX) up_wraps_next = up_wraps_reg + 1'b1;
            end
          end else if (is_dn) begin
            step_dn_next = 1'b1;
            dir_next     = 1'b0;
            if (prev_reg == '0) begin
              wrap_dn_next = 1'b1;
              if (dn_wraps_reg != STAT_MAX) dn_wraps_next = dn_wraps_reg + 1'b1;
            end
          end else if (is_jump) begin
            jump_evt      = 1'b1;
            jump_err_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase

    // clr beats the statistics but not a same-cycle jump; pulses survive.
    if (mon.clr) begin
      up_wraps_next  = '0;
      dn_wraps_next  = '0;
      stalled_next   = 1'b0;
      stall_cnt_next = 8'd0;
      jump_err_next  = jump_evt;
      if (state_next == ST_STALL) state_next = ST_TRACK;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_INIT;
      prev_reg      <= '0;
      stall_cnt_reg <= 8'd0;
      dir_reg       <= 1'b1;
      step_up_reg   <= 1'b0;
      step_dn_reg   <= 1'b0;
      wrap_up_reg   <= 1'b0;
      wrap_dn_reg   <= 1'b0;
      up_wraps_reg  <= '0;
      dn_wraps_reg  <= '0;
      stalled_reg   <= 1'b0;
      jump_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prev_reg      <= prev_next;
      stall_cnt_reg <= stall_cnt_next;
      dir_reg       <= dir_next;
      step_up_reg   <= step_up_next;
      step_dn_reg   <= step_dn_next;
      wrap_up_reg   <= wrap_up_next;
      wrap_dn_reg   <= wrap_dn_next;
      up_wraps_reg  <= up_wraps_next;
      dn_wraps_reg  <= dn_wraps_next;
      stalled_reg   <= stalled_next;
      jump_err_reg  <= jump_err_next;
    end
  end

  assign mon.dir      = dir_reg;
  assign mon.step_up  = step_up_reg;
  assign mon.step_dn  = step_dn_reg;
  assign mon.wrap_up  = wrap_up_reg;
  assign mon.wrap_dn  = wrap_dn_reg;
  assign mon.up_wraps = up_wraps_reg;
  assign mon.dn_wraps = dn_wraps_reg;
  assign mon.stalled  = stalled_reg;
  assign mon.jump_err = jump_err_reg;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Self-checking bench for count_wrap_monitor: directed scenarios followed by
// random stimulus, all checked every cycle against a behavioural model.
module tb_count_wrap_monitor;

  localparam int WIDTH     = 4;
  localparam int STALL_LIM = 8;
  localparam int STAT_W    = 8;
  localparam int MASK      = (1 << WIDTH) - 1;
  localparam int SMAX      = (1 << STAT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  count_wrap_monitor_if #(.WIDTH(WIDTH), .STAT_W(STAT_W)) mon_if ();

  count_wrap_monitor #(
    .WIDTH(WIDTH), .STALL_LIM(STALL_LIM), .STAT_W(STAT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(mon_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  bit m_seeded;
  int m_prev, m_run, m_upw, m_dnw;
  bit m_dir, m_stalled, m_jerr, m_su, m_sd, m_wu, m_wd;

  // pulse tallies for directed sections
  int cnt_su, cnt_sd, cnt_wu, cnt_wd;
  int cur;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the rules of the monitor to one registered sample.
  task automatic model_edge(input int c, input bit cl, input bit r);
    int d;
    bit jmp;
    m_su = 0; m_sd = 0; m_wu = 0; m_wd = 0; jmp = 0;
    if (r) begin
      m_seeded = 0; m_prev = 0; m_dir = 1; m_run = 0;
      m_stalled = 0; m_jerr = 0; m_upw = 0; m_dnw = 0;
      return;
    end
    if (!m_seeded) begin
      m_seeded = 1;
    end else begin
      d = (c - m_prev) & MASK;
      if (d == 0) begin
        if (!m_stalled) begin
          if (m_run < 255) m_run++;
          if (m_run >= STALL_LIM) m_stalled = 1;
        end
      end else begin
        m_run = 0;
        m_stalled = 0;
        if (d == 1) begin
          m_su = 1; m_dir = 1;
          if (m_prev == MASK) begin m_wu = 1; if (m_upw < SMAX) m_upw++; end
        end else if (d == MASK) begin
          m_sd = 1; m_dir = 0;
          if (m_prev == 0) begin m_wd = 1; if (m_dnw < SMAX) m_dnw++; end
        end else begin
          jmp = 1; m_jerr = 1;
        end
      end
    end
    if (cl) begin
      m_upw = 0; m_dnw = 0; m_stalled = 0; m_run = 0; m_jerr = jmp;
    end
    m_prev = c;
  endtask

  // One clock: drive inputs, advance model, compare every output.
  task automatic cycle(input int c, input bit cl, input bit r);
    mon_if.count_in = WIDTH'(c);
    mon_if.clr      = cl;
    rst             = r;
    cur             = c;
    @(posedge clk);
    #1;
    model_edge(c, cl, r);
    check_eq("dir",      32'(mon_if.dir),      32'(m_dir));
    check_eq("step_up",  32'(mon_if.step_up),  32'(m_su));
    check_eq("step_dn",  32'(mon_if.step_dn),  32'(m_sd));
    check_eq("wrap_up",  32'(mon_if.wrap_up),  32'(m_wu));
    check_eq("wrap_dn",  32'(mon_if.wrap_dn),  32'(m_wd));
    check_eq("up_wraps", 32'(mon_if.up_wraps), 32'(m_upw));
    check_eq("dn_wraps", 32'(mon_if.dn_wraps), 32'(m_dnw));
    check_eq("stalled",  32'(mon_if.stalled),  32'(m_stalled));
    check_eq("jump_err", 32'(mon_if.jump_err), 32'(m_jerr));
    cnt_su += int'(mon_if.step_up);
    cnt_sd += int'(mon_if.step_dn);
    cnt_wu += int'(mon_if.wrap_up);
    cnt_wd += int'(mon_if.wrap_dn);
  endtask

  // Two reset cycles holding v, then the seeding edge with v.
  task automatic restart(input int v);
    cycle(v, 0, 1);
    cycle(v, 0, 1);
    cycle(v, 0, 0);
    cnt_su = 0; cnt_sd = 0; cnt_wu = 0; cnt_wd = 0;
  endtask

  initial begin
    int hold_left;
    int r;
    int nv;
    bit cl, rs;
    mon_if.count_in = '0;
    mon_if.clr      = 1'b0;
    cnt_su = 0; cnt_sd = 0; cnt_wu = 0; cnt_wd = 0;

    // Reset: value 5 held through reset and the seeding edge.
    cycle(5, 0, 1);
    cycle(5, 0, 1);
    check_eq("rst_dir",     32'(mon_if.dir),     32'd1);
    check_eq("rst_stalled", 32'(mon_if.stalled), 32'd0);
    cycle(5, 0, 0);
    check_eq("init_no_pulse", 32'(mon_if.step_up | mon_if.step_dn | mon_if.jump_err), 32'd0);
    cycle(5, 0, 0);
    check_eq("hold_no_pulse", 32'(mon_if.step_up | mon_if.step_dn), 32'd0);
    cycle(6, 0, 0);
    check_eq("first_pulse", 32'(mon_if.step_up), 32'd1);

    // Up sweep 0..15,0,1
    restart(0);
    for (int i = 1; i <= 17; i++) cycle(i & MASK, 0, 0);
    check_eq("sweep_up_steps", 32'(cnt_su), 32'd17);
    check_eq("sweep_up_wraps", 32'(cnt_wu), 32'd1);
    check_eq("sweep_up_stat",  32'(mon_if.up_wraps), 32'd1);
    check_eq("sweep_up_dir",   32'(mon_if.dir), 32'd1);
    check_eq("sweep_up_jerr",  32'(mon_if.jump_err), 32'd0);

    // Down sweep 3,2,1,0,15,14
    restart(3);
    cycle(2, 0, 0);
    check_eq("sweep_dn_dir", 32'(mon_if.dir), 32'd0);
    cycle(1, 0, 0); cycle(0, 0, 0); cycle(15, 0, 0);
    check_eq("sweep_dn_wrap_pulse", 32'(mon_if.wrap_dn), 32'd1);
    cycle(14, 0, 0);
    check_eq("sweep_dn_steps", 32'(cnt_sd), 32'd5);
    check_eq("sweep_dn_wraps", 32'(cnt_wd), 32'd1);
    check_eq("sweep_dn_stat",  32'(mon_if.dn_wraps), 32'd1);

    // Stall: 7 for 10 cycles (first is a step from 6), then 8
    restart(6);
    for (int i = 0; i < 10; i++) begin
      cycle(7, 0, 0);
      if (i == 7) check_eq("stall_before_lim", 32'(mon_if.stalled), 32'd0);
      if (i == 8) check_eq("stall_at_lim",     32'(mon_if.stalled), 32'd1);
    end
    check_eq("stall_held", 32'(mon_if.stalled), 32'd1);
    cycle(8, 0, 0);
    check_eq("stall_clear", 32'(mon_if.stalled), 32'd0);
    check_eq("stall_exit_step", 32'(mon_if.step_up), 32'd1);

    // Jump 4 -> 9 -> 10, then clr
    restart(4);
    cycle(9, 0, 0);
    check_eq("jump_flag",   32'(mon_if.jump_err), 32'd1);
    check_eq("jump_nostep", 32'(mon_if.step_up | mon_if.step_dn), 32'd0);
    cycle(10, 0, 0);
    check_eq("jump_then_step", 32'(mon_if.step_up), 32'd1);
    cycle(10, 1, 0);
    check_eq("jump_cleared", 32'(mon_if.jump_err), 32'd0);

    // Saturation: 260 up wraps, then clr on a 15->0 step
    restart(0);
    for (int w = 0; w < 260; w++)
      for (int i = 1; i <= 16; i++) cycle(i & MASK, 0, 0);
    check_eq("sat_up_wraps", 32'(mon_if.up_wraps), 32'd255);
    for (int i = 1; i <= 15; i++) cycle(i, 0, 0);
    cycle(0, 1, 0);
    check_eq("clr_wrap_stat",  32'(mon_if.up_wraps), 32'd0);
    check_eq("clr_wrap_pulse", 32'(mon_if.wrap_up), 32'd1);

    // Random phase: mostly legal steps with holds, jumps, clr and resets
    hold_left = 0;
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 99));
      if (hold_left > 0) begin
        nv = cur;
        hold_left--;
      end else if (r < 40) nv = (cur + 1) & MASK;
      else if (r < 75) nv = (cur - 1) & MASK;
      else if (r < 85) begin
        nv = cur;
        hold_left = int'($urandom_range(2, 12));
      end else nv = int'($urandom_range(0, MASK));
      cl = ($urandom_range(0, 99) < 4);
      rs = ($urandom_range(0, 199) < 2);
      cycle(nv, cl, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_wrap_monitor.md
# count_wrap_monitor

Observer stage that sits directly downstream of `up_down_counter` and consumes its `count` output. It tracks the counter's step direction and emits single-cycle step and wrap pulses. It keeps saturating wrap statistics and flags stalls and illegal jumps (any change other than ±1 modulo 2^WIDTH). It drives no feedback into the counter and is used for on-chip checking and for the LED/status logic.

## Interface
- `WIDTH`, 4: width of the monitored count.
- `STALL_LIM`, 8: number of consecutive unchanged samples that sets `stalled`; legal range 2..255.
- `STAT_W`, 8: width of the wrap statistic counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `count_in` in WIDTH: count from the upstream counter, sampled every `clk`.
- `clr` in 1: synchronous clear of statistics and error flags.
- `dir` out 1: last legal step direction; 1 = up, 0 = down.
- `step_up` out 1: one-cycle pulse on a +1 step, including the wrap step.
- `step_dn` out 1: one-cycle pulse on a −1 step, including the wrap step.
- `wrap_up` out 1: one-cycle pulse on the 2^WIDTH−1 → 0 transition.
- `wrap_dn` out 1: one-cycle pulse on the 0 → 2^WIDTH−1 transition.
- `up_wraps` out STAT_W: saturating count of `wrap_up` events.
- `dn_wraps` out STAT_W: saturating count of `wrap_dn` events.
- `stalled` out 1: `count_in` has held unchanged for ≥ STALL_LIM samples.
- `jump_err` out 1: sticky flag for an illegal change.

## Operation
- Registers: `prev` (WIDTH), `stall_cnt` (8 bits, saturating), FSM state. All outputs are registered.
- FSM states: INIT, TRACK, STALL.
- **INIT** (entered on reset):
  - Next edge loads `prev <= count_in` and moves to TRACK.
  - Emits no pulses and makes no comparison.
- **TRACK**: each edge classifies `count_in` against `prev`, using modulo-2^WIDTH arithmetic.
  - Equal: increment `stall_cnt`. When it reaches STALL_LIM, set `stalled=1` and go to STALL.
  - `prev+1`: `step_up=1`, `dir<=1`, `stall_cnt<=0`. If `prev` is all-ones, also `wrap_up=1` and increment `up_wraps`.
  - `prev−1`: `step_dn=1`, `dir<=0`, `stall_cnt<=0`. If `prev==0`, also `wrap_dn=1` and increment `dn_wraps`.
  - Any other value: `jump_err<=1` (sticky), no step pulse, `dir` unchanged, `stall_cnt<=0`.
  - `prev<=count_in` on every edge.
- **STALL**:
  - `stalled` stays 1 while `count_in==prev`.
  - On the first change, classify the change exactly as in TRACK (pulses, error, stats), clear `stalled` and `stall_cnt`, and return to TRACK on the same edge.
- Statistic counters saturate at 2^STAT_W−1 and never roll over.
- `clr` (effective in any state, ignored while `rst` is high):
  - Sets `up_wraps`, `dn_wraps`, `jump_err`, `stalled` and `stall_cnt` to 0.
  - A stall in progress returns the FSM to TRACK.
  - Does not touch `prev`, `dir`, or the FSM INIT state.
  - If `clr` coincides with a wrap event, `clr` wins for the counter (result 0) but the wrap and step pulses are still emitted.
  - If `clr` coincides with an illegal jump, `jump_err` ends at 1 (the new event wins over the clear).
- Reset values, asserted whenever `rst` is high at an edge:
  - state INIT, `prev=0`, `dir=1`, `stall_cnt=0`.
  - `step_up`, `step_dn`, `wrap_up`, `wrap_dn`, `stalled`, `jump_err` all 0; `up_wraps` and `dn_wraps` 0.
  - Asserting `rst` mid-sweep or mid-stall discards history, and the first post-reset sample produces no pulse.
- For WIDTH=1, ±1 steps are indistinguishable. Classify them as up.

## Timing
- `count_in` is assumed to change on the same `clk` edge as the upstream register.
- Latency: a change visible after edge k is classified at edge k+1. Pulses are high for exactly the cycle after edge k+1.
- Back-to-back steps give pulses in consecutive cycles, with no gap required.
- `stalled` rises on the edge that registers the STALL_LIM-th consecutive equal sample. It falls on the edge that registers the change.
- After `rst` deasserts, the first comparison happens on the second edge: the INIT edge, then the first TRACK edge.
- Statistic outputs update on the same edge as their corresponding pulse.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `count_in=5`, then release. Required: all outputs 0 and `dir=1`; no pulse on the first post-reset edge; first pulse appears only after `count_in` changes.
- **Up sweep:** `count_in` 0,1,…,15,0,1, one per cycle. Required: 17 `step_up` pulses; exactly one `wrap_up`, in the cycle after 15→0 is registered; `up_wraps=1`; `dir=1`; `jump_err=0`.
- **Down sweep:** `count_in` 3,2,1,0,15,14. Required: 5 `step_dn` pulses; one `wrap_dn` on 0→15; `dn_wraps=1`; `dir=0` from the first step.
- **Stall:** `count_in` held at 7 for 10 cycles, then 8. Required: `stalled=1` on the 8th equal sample and held; it clears on the edge registering 8, together with one `step_up`.
- **Jump:** `count_in` 4→9→10, then pulse `clr`. Required: `jump_err=1` with no step pulse on 4→9; normal `step_up` on 9→10; `jump_err=0` after `clr`.
- **Saturation and clr priority:** 260 up wraps give `up_wraps=255`. Then `clr` asserted in the same cycle as a 15→0 step. Required: `up_wraps=0` and `wrap_up=1` in that cycle.
